// File: rtl/servo_pwm_multi.sv
// rtl/servo_pwm_multi.sv - multi-channel servo PWM generator with per-channel slew limiting
module servo_pwm_multi #(
    parameter int CLK_FREQ     = 50_000_000,
    parameter int NUM_CH       = 4,
    parameter int CH_W         = 4,
    parameter int PERIOD_US    = 20000,
    parameter int MIN_PULSE_US = 500,
    parameter int MAX_PULSE_US = 2500,
    parameter int ANGLE_MAX    = 180,
    parameter int INIT_ANGLE   = 90,
    parameter int SLEW_STEP    = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [CH_W-1:0]   cmd_ch,
    input  logic [7:0]        cmd_angle,
    output logic              cmd_err,
    output logic [NUM_CH-1:0] servo_pwm,
    output logic              frame_start,
    output logic [NUM_CH-1:0] settled
);

    localparam int CYC_US     = CLK_FREQ / 1_000_000;
    localparam int PERIOD_CYC = PERIOD_US * CYC_US;
    localparam int MIN_CYC    = MIN_PULSE_US * CYC_US;
    localparam int CPD        = ((MAX_PULSE_US - MIN_PULSE_US) * CYC_US) / ANGLE_MAX;
    localparam int CNT_W      = $clog2(PERIOD_CYC);
    localparam int WMAX       = MIN_CYC + ANGLE_MAX * CPD;

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(PERIOD_CYC - 1);
    localparam logic [CNT_W-1:0] SLEW_CNT = CNT_W'(PERIOD_CYC - 2);
    localparam logic [CNT_W-1:0] MIN_W    = CNT_W'(MIN_CYC);
    localparam logic [CNT_W-1:0] CPD_W    = CNT_W'(CPD);
    localparam logic [CNT_W-1:0] INIT_W   = CNT_W'(MIN_CYC + INIT_ANGLE * CPD);
    localparam logic [7:0]       AMAX8    = 8'(ANGLE_MAX);
    localparam logic [7:0]       INIT8    = 8'(INIT_ANGLE);
    localparam logic [7:0]       STEP8    = 8'(SLEW_STEP);
    localparam logic [CH_W:0]    NUM_CH_W = (CH_W + 1)'(NUM_CH);

    if (NUM_CH < 1 || NUM_CH > 16) begin : g_bad_num_ch
        $error("servo_pwm_multi: NUM_CH must be 1..16");
    end
    if ((1 << CH_W) < NUM_CH) begin : g_bad_ch_w
        $error("servo_pwm_multi: CH_W too narrow for NUM_CH");
    end
    if (ANGLE_MAX < 1 || ANGLE_MAX > 255 || INIT_ANGLE > ANGLE_MAX || SLEW_STEP < 0 || SLEW_STEP > 255) begin : g_bad_angle
        $error("servo_pwm_multi: illegal angle or slew parameters");
    end
    if (PERIOD_CYC < 4 || WMAX >= PERIOD_CYC) begin : g_bad_width
        $error("servo_pwm_multi: width(ANGLE_MAX) must be below PERIOD_CYC");
    end

    function automatic logic [CNT_W-1:0] width_of(input logic [7:0] a);
        return MIN_W + CNT_W'(a) * CPD_W;
    endfunction

    // One slew step toward the target; never overshoots, never wraps.
    function automatic logic [7:0] slew(input logic [7:0] cur, input logic [7:0] tgt);
        logic [7:0] r;
        if (SLEW_STEP == 0) begin
            r = tgt;
        end else if (tgt > cur) begin
            r = ((tgt - cur) <= STEP8) ? tgt : cur + STEP8;
        end else begin
            r = ((cur - tgt) <= STEP8) ? tgt : cur - STEP8;
        end
        return r;
    endfunction

    logic [CNT_W-1:0]  frame_cnt_q, frame_cnt_d;
    logic [7:0]        target_q [NUM_CH];
    logic [7:0]        target_d [NUM_CH];
    logic [7:0]        cur_q    [NUM_CH];
    logic [7:0]        cur_d    [NUM_CH];
    logic [CNT_W-1:0]  width_q  [NUM_CH];
    logic [CNT_W-1:0]  width_d  [NUM_CH];
    logic [NUM_CH-1:0] pwm_q, pwm_d;
    logic [NUM_CH-1:0] settled_q, settled_d;
    logic              frame_start_q, frame_start_d;
    logic              cmd_err_q, cmd_err_d;
    logic              cmd_ready_q;
    logic              accept, ch_ok;
    logic [7:0]        angle_c;

    always_comb begin
        accept        = cmd_valid && cmd_ready_q;
        ch_ok         = {1'b0, cmd_ch} < NUM_CH_W;
        angle_c       = (cmd_angle > AMAX8) ? AMAX8 : cmd_angle;
        frame_cnt_d   = (frame_cnt_q == LAST_CNT) ? '0 : frame_cnt_q + CNT_W'(1);
        frame_start_d = (frame_cnt_q == '0);
        cmd_err_d     = accept && !ch_ok;
        pwm_d         = '0;
        settled_d     = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            target_d[i] = target_q[i];
            if (accept && ch_ok && cmd_ch == CH_W'(i)) begin
                target_d[i] = angle_c;
            end
            // Slew uses the pre-write target, so a same-cycle command waits a frame.
            cur_d[i] = (frame_cnt_q == SLEW_CNT) ? slew(cur_q[i], target_q[i]) : cur_q[i];
            width_d[i] = (frame_cnt_q == LAST_CNT) ? width_of(cur_q[i]) : width_q[i];
            pwm_d[i] = (frame_cnt_q < width_q[i]);
            settled_d[i] = (cur_d[i] == target_d[i]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            frame_cnt_q   <= '0;
            pwm_q         <= '0;
            settled_q     <= '1;
            frame_start_q <= 1'b0;
            cmd_err_q     <= 1'b0;
            cmd_ready_q   <= 1'b0;
            for (int i = 0; i < NUM_CH; i++) begin
                target_q[i] <= INIT8;
                cur_q[i]    <= INIT8;
                width_q[i]  <= INIT_W;
            end
        end else begin
            frame_cnt_q   <= frame_cnt_d;
            pwm_q         <= pwm_d;
            settled_q     <= settled_d;
            frame_start_q <= frame_start_d;
            cmd_err_q     <= cmd_err_d;
            cmd_ready_q   <= 1'b1;
            for (int i = 0; i < NUM_CH; i++) begin
                target_q[i] <= target_d[i];
                cur_q[i]    <= cur_d[i];
                width_q[i]  <= width_d[i];
            end
        end
    end

    assign cmd_ready   = cmd_ready_q;
    assign cmd_err     = cmd_err_q;
    assign servo_pwm   = pwm_q;
    assign frame_start = frame_start_q;
    assign settled     = settled_q;

endmodule

// File: doc/servo_pwm_multi.md
Name: servo_pwm_multi

Overview:
Multi-channel hobby-servo PWM generator with per-channel slew-rate limiting. It replaces the single-channel angle-to-pulse driver in the servo/gimbal path. A valid/ready command port writes one channel's target angle per accepted beat. All channels share one frame counter. Each channel's pulse width is latched once per frame, so outputs never glitch mid-period.

Parameters:
CLK_FREQ, 50_000_000, system clock frequency in Hz
NUM_CH, 4, number of servo channels (1..16)
CH_W, 4, width of channel index (must satisfy 2**CH_W >= NUM_CH)
PERIOD_US, 20000, PWM frame period in microseconds
MIN_PULSE_US, 500, pulse width at 0 degrees
MAX_PULSE_US, 2500, nominal pulse width at ANGLE_MAX
ANGLE_MAX, 180, maximum legal angle in degrees
INIT_ANGLE, 90, target and current angle of every channel after reset
SLEW_STEP, 2, maximum change in degrees per frame per channel; 0 means jump straight to target

Ports:
clk  input  1  system clock
rst  input  1  synchronous reset, active-high
cmd_valid  input  1  command present
cmd_ready  output  1  command accepted when cmd_valid && cmd_ready
cmd_ch  input  CH_W  target channel index
cmd_angle  input  8  requested angle in degrees
cmd_err  output  1  one-cycle pulse: accepted command had cmd_ch >= NUM_CH
servo_pwm  output  NUM_CH  PWM outputs, one bit per channel
frame_start  output  1  one-cycle pulse, coincident with the rising edge of servo_pwm
settled  output  NUM_CH  per channel: current angle == target angle

Behaviour:
- Derived constants (elaboration-time integers):
  - CYC_US = CLK_FREQ/1_000_000
  - PERIOD_CYC = PERIOD_US*CYC_US
  - MIN_CYC = MIN_PULSE_US*CYC_US
  - CPD = ((MAX_PULSE_US-MIN_PULSE_US)*CYC_US)/ANGLE_MAX, truncated
  - width(a) = MIN_CYC + a*CPD. Default values: 25000 + a*555.
- frame_cnt counts 0..PERIOD_CYC-1, then wraps to 0. It is free-running.
- Reset, and the cycle after rst deasserts:
  - frame_cnt=0; all targets and current angles = INIT_ANGLE.
  - width_reg = width(INIT_ANGLE).
  - servo_pwm=0, frame_start=0, cmd_err=0, cmd_ready=0, settled=all 1.
- cmd_ready is 1 in every cycle after reset, 0 while rst=1. Accepting a command takes one cycle and never stalls.
- On accept:
  - cmd_angle > ANGLE_MAX is clamped to ANGLE_MAX.
  - If cmd_ch < NUM_CH, target[cmd_ch] is written on the next edge.
  - Otherwise no state changes and cmd_err pulses 1 on the next cycle.
  - Back-to-back commands to the same channel: the last write wins.
- Slew update, at frame_cnt == PERIOD_CYC-2, for every channel:
  - d = target-cur. If |d| <= SLEW_STEP or SLEW_STEP==0, then cur = target.
  - Otherwise cur moves SLEW_STEP toward target. No overshoot and no wrap (unsigned, 0..ANGLE_MAX).
  - A command accepted in this same cycle is not seen until the next frame's update.
- Width latch, at frame_cnt == PERIOD_CYC-1: width_reg[i] = width(cur[i]). Use the multiply-and-add only; no divider in RTL.
- Output, registered: servo_pwm[i] <= (frame_cnt < width_reg[i]).
  - Each channel is high for exactly width_reg[i] clocks per frame.
  - All channels rise on the same edge, one cycle after frame_cnt==0.
  - frame_start <= (frame_cnt==0).
- settled[i] is registered and reflects cur==target after each update or command write.
- Reset asserted mid-frame: all outputs drop to 0 on the next edge. The frame restarts from 0 after deassert; no partial pulse completes.
- Width rules:
  - frame_cnt width = clog2(PERIOD_CYC).
  - Width arithmetic is performed at clog2(PERIOD_CYC) bits. A parameter set with width(ANGLE_MAX) >= PERIOD_CYC is illegal and must be rejected by an elaboration check.

Test Plan:
1. CLK_FREQ=1_000_000, SLEW_STEP=0, no commands after reset:
   - every channel pulses 500+90*11=1490 cycles in a 20000-cycle period;
   - frame_start coincides with each rising edge;
   - settled=all 1.
2. SLEW_STEP=0, write ch1=0 and ch2=180 mid-frame:
   - the current frame is unchanged;
   - the next frame gives ch1=500 cycles and ch2=2480 cycles;
   - ch0 and ch3 stay at 1490.
3. SLEW_STEP=2, write ch0=96 from 90:
   - successive frame widths are 1512, 1534, 1556;
   - settled[0] stays 0 until the frame with width 1556, then goes 1.
4. Write cmd_angle=250 to ch3 -> clamped, ch3 pulse = 2480. Write cmd_ch=5 -> cmd_err pulses one cycle and no channel changes.
5. Command accepted exactly at frame_cnt=PERIOD_CYC-2 (SLEW_STEP=0) -> the next frame keeps the old width; the frame after that shows the new width.
6. Assert rst for 3 cycles while servo_pwm is high -> servo_pwm=0 on the next edge. After deassert, all widths return to 1490 and the first rising edge occurs one cycle after frame_cnt=0.
